// File: rtl/lightcube_pkg.sv
// Shared definitions for the light-cube frame path: scheduler state encoding
// and the frame payload size.
package lightcube_pkg;

    localparam logic S_DEFAULT = 1'b0;
    localparam logic S_UART    = 1'b1;

    // One frame is 64 bytes (8x8 columns of 8 LEDs).
    localparam int FRAME_BITS = 8 * 64;

    typedef enum logic {
        STATE_DEFAULT = S_DEFAULT,
        STATE_UART    = S_UART
    } sched_state_t;

endpackage : lightcube_pkg

// File: rtl/frame_source_scheduler_if.sv
// Bundle of source-select inputs and frame-buffer-facing outputs of the
// frame source scheduler.
interface frame_source_scheduler_if #(
    parameter int DROP_W = 16
);
    logic              mode_sw;
    logic              uart_frame_valid;
    logic              default_frame_valid;
    logic              display_mode;
    logic              frame_valid_uart_o;
    logic              frame_valid_default_o;
    logic              default_next;
    logic              state_o;
    logic [DROP_W-1:0] dropped_cnt;

    // master: whoever drives the source pulses and observes the scheduler
    modport master (
        output mode_sw,
        output uart_frame_valid,
        output default_frame_valid,
        input  display_mode,
        input  frame_valid_uart_o,
        input  frame_valid_default_o,
        input  default_next,
        input  state_o,
        input  dropped_cnt
    );

    modport slave (
        input  mode_sw,
        input  uart_frame_valid,
        input  default_frame_valid,
        output display_mode,
        output frame_valid_uart_o,
        output frame_valid_default_o,
        output default_next,
        output state_o,
        output dropped_cnt
    );
endinterface : frame_source_scheduler_if

// File: rtl/frame_source_scheduler_cycle_timer.sv
// Modulo-LIMIT cycle counter: counts while enabled, clears on request, and
// flags the cycle in which the count sits at LIMIT-1 and is about to wrap.
module cycle_timer #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic count,
    input  logic clear,
    output logic expire
);
    localparam int W = $clog2(LIMIT);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_reg;

    // Clear takes priority, so an expiry is never reported in a clearing cycle.
    assign expire = count && !clear && (cnt_reg == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (count) begin
            if (cnt_reg == LAST) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end
endmodule : cycle_timer

// File: rtl/frame_source_scheduler.sv
// Chooses between UART-streamed and built-in animation frames, paces the
// animation generator and falls back to it when the UART stream stalls.
module frame_source_scheduler
    import lightcube_pkg::*;
#(
    parameter int HOLD_CYCLES  = 5_000_000,
    parameter int UART_TIMEOUT = 100_000_000,
    parameter int DROP_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    frame_source_scheduler_if.slave  bus
);
    sched_state_t      state_reg;
    logic              display_mode_reg;
    logic              fv_uart_reg;
    logic              fv_default_reg;
    logic              default_next_reg;
    logic [DROP_W-1:0] dropped_reg;

    logic in_uart;
    logic hold_expire;
    logic idle_expire;
    logic go_uart;
    logic fallback;
    logic drop_frame;

    assign in_uart = (state_reg == STATE_UART);

    // A UART frame in the expiry cycle clears the idle timer, which masks the
    // expiry: the frame wins over the timeout.
    assign go_uart    = !in_uart && bus.uart_frame_valid && bus.mode_sw;
    assign fallback   = in_uart && (!bus.mode_sw || idle_expire);
    assign drop_frame = bus.uart_frame_valid && !bus.mode_sw;

    cycle_timer #(.LIMIT(HOLD_CYCLES)) u_hold_timer (
        .clk    (clk),
        .rst    (rst),
        .count  (!in_uart),
        .clear  (fallback),
        .expire (hold_expire)
    );

    cycle_timer #(.LIMIT(UART_TIMEOUT)) u_idle_timer (
        .clk    (clk),
        .rst    (rst),
        .count  (in_uart),
        .clear  (!in_uart || bus.uart_frame_valid),
        .expire (idle_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= STATE_DEFAULT;
            display_mode_reg <= 1'b0;
            fv_uart_reg      <= 1'b0;
            fv_default_reg   <= 1'b0;
            default_next_reg <= 1'b0;
        end else begin
            case (state_reg)
                STATE_DEFAULT: begin
                    default_next_reg <= hold_expire;
                    fv_uart_reg      <= go_uart;
                    // The frame that triggers the switch takes the slot; any
                    // coincident animation frame is discarded.
                    fv_default_reg   <= bus.default_frame_valid && !go_uart;
                    if (go_uart) begin
                        state_reg        <= STATE_UART;
                        display_mode_reg <= 1'b1;
                    end
                end
                STATE_UART: begin
                    fv_default_reg <= 1'b0;
                    if (fallback) begin
                        state_reg        <= STATE_DEFAULT;
                        display_mode_reg <= 1'b0;
                        fv_uart_reg      <= 1'b0;
                        default_next_reg <= 1'b1;
                    end else begin
                        fv_uart_reg      <= bus.uart_frame_valid;
                        default_next_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg        <= STATE_DEFAULT;
                    display_mode_reg <= 1'b0;
                    fv_uart_reg      <= 1'b0;
                    fv_default_reg   <= 1'b0;
                    default_next_reg <= 1'b0;
                end
            endcase
        end
    end

    // UART frames arriving with the switch on animation are discarded in
    // either state; the count sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dropped_reg <= '0;
        end else if (drop_frame && (dropped_reg != {DROP_W{1'b1}})) begin
            dropped_reg <= dropped_reg + 1'b1;
        end
    end

    assign bus.display_mode          = display_mode_reg;
    assign bus.frame_valid_uart_o    = fv_uart_reg;
    assign bus.frame_valid_default_o = fv_default_reg;
    assign bus.default_next          = default_next_reg;
    assign bus.state_o               = (state_reg == STATE_UART);
    assign bus.dropped_cnt           = dropped_reg;
endmodule : frame_source_scheduler

// File: tb/tb_frame_source_scheduler.sv
// Directed bench for frame_source_scheduler with HOLD_CYCLES = 4 and
// UART_TIMEOUT = 10.
module tb_frame_source_scheduler;
    localparam int DROP_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests  = 0;
    int   failed = 0;

    frame_source_scheduler_if #(.DROP_W(DROP_W)) bus ();

    frame_source_scheduler #(
        .HOLD_CYCLES  (4),
        .UART_TIMEOUT (10),
        .DROP_W       (DROP_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dm"}, 32'(bus.display_mode), 0);
        chk({tag, "_fvu"}, 32'(bus.frame_valid_uart_o), 0);
        chk({tag, "_fvd"}, 32'(bus.frame_valid_default_o), 0);
        chk({tag, "_dn"}, 32'(bus.default_next), 0);
        chk({tag, "_st"}, 32'(bus.state_o), 0);
        chk({tag, "_drop"}, 32'(bus.dropped_cnt), 0);
    endtask

    initial begin
        bus.mode_sw             = 1'b0;
        bus.uart_frame_valid    = 1'b0;
        bus.default_frame_valid = 1'b0;

        // Reset state
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;

        // 1: default_next at clk 4, 8, 12 after release
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("hold_dn_clk%0d", k), 32'(bus.default_next), (k % 4 == 0) ? 1 : 0);
        end
        chk("idle_dm", 32'(bus.display_mode), 0);
        chk("idle_drop", 32'(bus.dropped_cnt), 0);
        $display("[TB] step1 hold pacing done");

        // 2: UART frames with switch on animation are dropped and counted
        for (int k = 0; k < 3; k++) begin
            bus.uart_frame_valid = 1'b1;
            tick();
            chk($sformatf("drop_fvu_%0d", k), 32'(bus.frame_valid_uart_o), 0);
            bus.uart_frame_valid = 1'b0;
            tick();
        end
        chk("drop_cnt3", 32'(bus.dropped_cnt), 3);
        chk("drop_state", 32'(bus.state_o), 0);
        $display("[TB] step2 drops=%0d", bus.dropped_cnt);

        // 3: switch to UART; simultaneous animation frame is dropped
        bus.mode_sw             = 1'b1;
        bus.uart_frame_valid    = 1'b1;
        bus.default_frame_valid = 1'b1;
        tick();
        bus.uart_frame_valid    = 1'b0;
        bus.default_frame_valid = 1'b0;
        chk("enter_dm", 32'(bus.display_mode), 1);
        chk("enter_fvu", 32'(bus.frame_valid_uart_o), 1);
        chk("enter_fvd", 32'(bus.frame_valid_default_o), 0);
        chk("enter_st", 32'(bus.state_o), 1);
        $display("[TB] step3 entered UART");

        // 4a: 10 idle clocks -> timeout fallback
        for (int k = 0; k < 9; k++) tick();
        chk("idle9_st", 32'(bus.state_o), 1);
        chk("idle9_fvu", 32'(bus.frame_valid_uart_o), 0);
        tick();
        chk("tmo_st", 32'(bus.state_o), 0);
        chk("tmo_dm", 32'(bus.display_mode), 0);
        chk("tmo_dn", 32'(bus.default_next), 1);
        chk("tmo_drop", 32'(bus.dropped_cnt), 3);
        $display("[TB] step4a timeout fallback");

        // 4b: re-enter, then a frame on the expiry clock keeps UART
        bus.uart_frame_valid = 1'b1;
        tick();
        bus.uart_frame_valid = 1'b0;
        chk("reenter_st", 32'(bus.state_o), 1);
        chk("reenter_dn", 32'(bus.default_next), 0);
        for (int k = 0; k < 9; k++) tick();
        bus.uart_frame_valid = 1'b1;
        tick();
        bus.uart_frame_valid = 1'b0;
        chk("race_st", 32'(bus.state_o), 1);
        chk("race_fvu", 32'(bus.frame_valid_uart_o), 1);
        tick();
        chk("race_after_st", 32'(bus.state_o), 1);
        chk("race_after_fvu", 32'(bus.frame_valid_uart_o), 0);
        $display("[TB] step4b frame beat timeout");

        // 5: switch off with a coincident UART frame -> fallback, frame counted
        bus.mode_sw             = 1'b0;
        bus.uart_frame_valid    = 1'b1;
        bus.default_frame_valid = 1'b1;
        tick();
        bus.uart_frame_valid    = 1'b0;
        chk("sw_st", 32'(bus.state_o), 0);
        chk("sw_dm", 32'(bus.display_mode), 0);
        chk("sw_dn", 32'(bus.default_next), 1);
        chk("sw_fvu", 32'(bus.frame_valid_uart_o), 0);
        chk("sw_fvd", 32'(bus.frame_valid_default_o), 0);
        chk("sw_drop", 32'(bus.dropped_cnt), 4);
        tick();
        bus.default_frame_valid = 1'b0;
        chk("pass_fvd", 32'(bus.frame_valid_default_o), 1);
        chk("pass_dn", 32'(bus.default_next), 0);
        $display("[TB] step5 switch fallback");

        // 6a: async reset mid-hold (hold_cnt = 2)
        tick();
        chk("pre_rst_fvd", 32'(bus.frame_valid_default_o), 0);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_hold");
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("post_rst_dn_clk%0d", k), 32'(bus.default_next), (k == 4) ? 1 : 0);
        end
        $display("[TB] step6a reset mid-hold");

        // 6b: async reset while in UART with a strobe high
        bus.mode_sw          = 1'b1;
        bus.uart_frame_valid = 1'b1;
        tick();
        bus.uart_frame_valid = 1'b0;
        chk("pre_rst_st", 32'(bus.state_o), 1);
        chk("pre_rst_fvu", 32'(bus.frame_valid_uart_o), 1);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_uart");
        rst = 1'b0;
        tick();
        chk("post_rst_st", 32'(bus.state_o), 0);
        $display("[TB] step6b reset in UART");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule : tb_frame_source_scheduler
